c3lib_and_reduce_filt: RTL and testbench

- Parametrised, registered successor to the 2-input AND primitive.
- ANDs up to WIDTH maskable inputs, with optional per-input 2-flop synchronisers.
- Result is hysteresis-filtered: the output changes only after the raw AND has held its new value for a programmable number of consecutive cycles.
- Used to combine ready/lock/status indications from multiple AIB channels into one glitch-free, debounced qualifier.

---
 rtl/c3lib_and_reduce_filt.sv | 153 +++++++++++++++
 tb/tb_c3lib_and_reduce_filt.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/c3lib_and_reduce_filt.sv
// Masked AND-reduce of WIDTH status inputs with optional 2-flop synchronisers and a
// hysteresis filter, so the combined qualifier only moves after the raw AND has settled.
//   state  | meaning
//   ST_LO  | out = 0, raw low or just reset
//   ST_QHI | out = 0, counting consecutive raw-high cycles
//   ST_HI  | out = 1, raw high
//   ST_QLO | out = 1, counting consecutive raw-low cycles
module c3lib_and_reduce_filt #(
  parameter int WIDTH        = 4,
  parameter int SYNC_EN      = 1,
  parameter int ASSERT_CNT   = 4,
  parameter int DEASSERT_CNT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out,
  output logic             out_rise,
  output logic             out_fall
);

  localparam int MAX_CNT = (ASSERT_CNT > DEASSERT_CNT) ? ASSERT_CNT : DEASSERT_CNT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_CNT);
  localparam logic [CW-1:0] CNT_A   = CW'(ASSERT_CNT);
  localparam logic [CW-1:0] CNT_D   = CW'(DEASSERT_CNT);

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    ST_QHI = 2'd1,
    ST_HI  = 2'd2,
    ST_QLO = 2'd3
  } state_t;

  logic [WIDTH-1:0] s_data;
  logic             raw;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  if (SYNC_EN != 0) begin : g_sync
    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
      meta_d = in_data;
      sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q <= '0;
        sync_q <= '0;
      end else begin
        meta_q <= meta_d;
        sync_q <= sync_d;
      end
    end

    assign s_data = sync_q;
  end else begin : g_nosync
    assign s_data = in_data;
  end

  // An all-zero mask would make the AND trivially true; treat it as never qualified.
  assign raw = (|in_mask) & (&(s_data | ~in_mask));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
    case (state_q)
      ST_LO: begin
        if (raw) begin
          if (ASSERT_CNT == 1) begin
            state_d = ST_HI;
            cnt_d   = '0;
          end else begin
            state_d = ST_QHI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_QHI: begin
        if (!raw) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_A) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HI: begin
        if (!raw) begin
          if (DEASSERT_CNT == 1) begin
            state_d = ST_LO;
            cnt_d   = '0;
          end else begin
            state_d = ST_QLO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_QLO: begin
        if (raw) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_D) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase

    // Pulses are computed from the next out value so they line up with the registered out.
    out_d  = (state_d == ST_HI) || (state_d == ST_QLO);
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign out      = out_q;
  assign out_rise = rise_q;
  assign out_fall = fall_q;

endmodule

// File: tb/tb_c3lib_and_reduce_filt.sv
// Bench for c3lib_and_reduce_filt: four configurations share one stimulus stream and are
// compared every cycle against a run-length reference model, plus directed corner cases.
module tb_c3lib_and_reduce_filt;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic [3:0] in_mask;
  logic [3:0] o_out, o_rise, o_fall;

  int checks = 0;
  int errors = 0;

  // instance 0: A4/D1, 1: A4/D3, 2: sync A1/D1, 3: A255/D1
  int acnt[4] = '{4, 4, 1, 255};
  int dcnt[4] = '{1, 3, 1, 1};
  int syn [4] = '{0, 0, 1, 0};

  c3lib_and_reduce_filt #(.WIDTH(4), .SYNC_EN(0), .ASSERT_CNT(4), .DEASSERT_CNT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_mask(in_mask),
    .out(o_out[0]), .out_rise(o_rise[0]), .out_fall(o_fall[0]));
  c3lib_and_reduce_filt #(.WIDTH(4), .SYNC_EN(0), .ASSERT_CNT(4), .DEASSERT_CNT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_mask(in_mask),
    .out(o_out[1]), .out_rise(o_rise[1]), .out_fall(o_fall[1]));
  c3lib_and_reduce_filt #(.WIDTH(4), .SYNC_EN(1), .ASSERT_CNT(1), .DEASSERT_CNT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_mask(in_mask),
    .out(o_out[2]), .out_rise(o_rise[2]), .out_fall(o_fall[2]));
  c3lib_and_reduce_filt #(.WIDTH(4), .SYNC_EN(0), .ASSERT_CNT(255), .DEASSERT_CNT(1)) u_d (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_mask(in_mask),
    .out(o_out[3]), .out_rise(o_rise[3]), .out_fall(o_fall[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: out flips once the opposite raw value has run for the threshold.
  logic [3:0] m_s1[4], m_s2[4];
  logic       m_out[4], m_prev[4];
  int         m_run[4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = '0; m_s2[i] = '0; m_out[i] = 0; m_prev[i] = 0; m_run[i] = 0;
    end
  endtask

  task automatic model_update(input logic [3:0] d, input logic [3:0] m);
    logic [3:0] sv;
    logic       raw;
    for (int i = 0; i < 4; i++) begin
      sv  = (syn[i] != 0) ? m_s2[i] : d;
      raw = (m != 4'h0) && ((sv | ~m) == 4'hF);
      m_prev[i] = m_out[i];
      if (raw != m_out[i]) begin
        m_run[i]++;
        if (m_run[i] >= (m_out[i] ? dcnt[i] : acnt[i])) begin
          m_out[i] = raw;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = d;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_out%0d", i),  o_out[i],  m_out[i]);
      chk($sformatf("model_rise%0d", i), o_rise[i], m_out[i] & ~m_prev[i]);
      chk($sformatf("model_fall%0d", i), o_fall[i], ~m_out[i] & m_prev[i]);
    end
  endtask

  // Called at a negedge: apply inputs for this cycle, check, advance one clock.
  task automatic step(input logic [3:0] d, input logic [3:0] m);
    in_data = d;
    in_mask = m;
    check_model();
    @(posedge clk);
    model_update(d, m);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_out%0d", tag, i),  o_out[i],  1'b0);
      chk($sformatf("%s_rise%0d", tag, i), o_rise[i], 1'b0);
      chk($sformatf("%s_fall%0d", tag, i), o_fall[i], 1'b0);
    end
  endtask

  // Called at a negedge: reset asserted between edges, released at a later negedge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] data;
    logic [3:0] mask;
    logic       a_out;
    logic       a_rise;
    logic       a_fall;
    int         c_exp;   // -1: not checked by the table
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] d, input logic [3:0] m, input logic ao,
                     input logic ar, input logic af, input int ce);
    vec_t v;
    v.data = d; v.mask = m; v.a_out = ao; v.a_rise = ar; v.a_fall = af; v.c_exp = ce;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n   = 1'b0;
    in_data = '0;
    in_mask = 4'hF;
    model_reset();

    // Basic assert/deassert, glitch rejection, masking on instance 0; sync latency on 2.
    for (int k = 0; k < 10; k++)
      add(4'hF, 4'hF, k >= 4, k == 4, 1'b0, (k >= 3) ? 1 : 0);
    add(4'h7, 4'hF, 1'b1, 1'b0, 1'b0, 1);
    add(4'h7, 4'hF, 1'b0, 1'b0, 1'b1, 1);
    add(4'h7, 4'hF, 1'b0, 1'b0, 1'b0, 1);
    for (int k = 0; k < 3; k++) add(4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 0);
    add(4'hE, 4'hF, 1'b0, 1'b0, 1'b0, -1);
    add(4'hE, 4'hF, 1'b0, 1'b0, 1'b0, -1);
    for (int k = 0; k < 5; k++) add(4'h3, 4'h3, k == 4, k == 4, 1'b0, -1);
    for (int k = 0; k < 20; k++) add(4'hF, 4'h0, k == 0, 1'b0, k == 1, -1);

    #1;
    check_all_zero("in_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      in_data = tbl[k].data;
      in_mask = tbl[k].mask;
      chk($sformatf("tbl%0d_a_out", k),  o_out[0],  tbl[k].a_out);
      chk($sformatf("tbl%0d_a_rise", k), o_rise[0], tbl[k].a_rise);
      chk($sformatf("tbl%0d_a_fall", k), o_fall[0], tbl[k].a_fall);
      if (tbl[k].c_exp >= 0)
        chk($sformatf("tbl%0d_c_out", k), o_out[2], tbl[k].c_exp[0]);
      step(tbl[k].data, tbl[k].mask);
    end

    // Dropout shorter than DEASSERT_CNT=3 keeps instance 1 high.
    async_reset("pre_drop");
    repeat (8) step(4'hF, 4'hF);
    chk("drop_b_hi", o_out[1], 1'b1);
    repeat (2) begin
      step(4'h0, 4'hF);
      chk("drop_b_hold", o_out[1], 1'b1);
    end
    repeat (3) begin
      step(4'hF, 4'hF);
      chk("drop_b_after", o_out[1], 1'b1);
      chk("drop_b_nofall", o_fall[1], 1'b0);
    end

    // ASSERT_CNT=255 boundary on instance 3.
    async_reset("pre_sat");
    for (int k = 0; k < 254; k++) begin
      chk("sat254_out", o_out[3], 1'b0);
      step(4'hF, 4'hF);
    end
    chk("sat254_out", o_out[3], 1'b0);
    step(4'h0, 4'hF);
    chk("sat254_low", o_out[3], 1'b0);
    for (int k = 0; k < 255; k++) begin
      chk("sat255_wait", o_out[3], 1'b0);
      step(4'hF, 4'hF);
    end
    chk("sat255_out", o_out[3], 1'b1);
    chk("sat255_rise", o_rise[3], 1'b1);

    // Async reset while instance 0 is qualifying (count 2) and others are high.
    async_reset("pre_mid");
    repeat (10) step(4'hF, 4'hF);
    step(4'h7, 4'hF);
    step(4'hF, 4'hF);
    step(4'hF, 4'hF);
    chk("mid_b_hi", o_out[1], 1'b1);
    async_reset("mid_rst");
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_wait", o_out[0], 1'b0);
      chk("post_rst_nofall", o_fall[1], 1'b0);
      step(4'hF, 4'hF);
    end
    chk("post_rst_out", o_out[0], 1'b1);
    chk("post_rst_rise", o_rise[0], 1'b1);

    // Randomised runs, mask changes and occasional mid-cycle resets.
    begin
      logic [3:0] d, m;
      m = 4'hF;
      for (int it = 0; it < 1500; it++) begin
        d = ($urandom_range(0, 9) < 6) ? 4'hF : 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0)
          m = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        repeat ($urandom_range(1, 6)) step(d, m);
        if ($urandom_range(0, 99) == 0)
          async_reset("rand_rst");
      end
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
